// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared encodings for the SCHOLAR RISC-V write-back stage.
//   GPR_*  : source select for the GPR write-back value
//   CSR_*  : CSR operation code; CSR_IDLE means no CSR write
//   MEM_*  : load width and signedness
//   wb_load_format() : aligns and extends load data for RV32 and RV64
// -----------------------------------------------------------------------------
package core_pkg;

  localparam int GPR_CTRL_WIDTH = 3;
  localparam int CSR_CTRL_WIDTH = 2;
  localparam int MEM_CTRL_WIDTH = 3;

  localparam logic [GPR_CTRL_WIDTH-1:0] GPR_IDLE  = 3'd0;
  localparam logic [GPR_CTRL_WIDTH-1:0] GPR_ALU   = 3'd1;
  localparam logic [GPR_CTRL_WIDTH-1:0] GPR_PRGMC = 3'd2;
  localparam logic [GPR_CTRL_WIDTH-1:0] GPR_OP3   = 3'd3;
  localparam logic [GPR_CTRL_WIDTH-1:0] GPR_MEM   = 3'd4;

  localparam logic [CSR_CTRL_WIDTH-1:0] CSR_IDLE  = 2'd0;
  localparam logic [CSR_CTRL_WIDTH-1:0] CSR_WRITE = 2'd1;
  localparam logic [CSR_CTRL_WIDTH-1:0] CSR_SET   = 2'd2;
  localparam logic [CSR_CTRL_WIDTH-1:0] CSR_CLEAR = 2'd3;

  localparam logic [MEM_CTRL_WIDTH-1:0] MEM_RB  = 3'd0;
  localparam logic [MEM_CTRL_WIDTH-1:0] MEM_RBU = 3'd1;
  localparam logic [MEM_CTRL_WIDTH-1:0] MEM_RH  = 3'd2;
  localparam logic [MEM_CTRL_WIDTH-1:0] MEM_RHU = 3'd3;
  localparam logic [MEM_CTRL_WIDTH-1:0] MEM_RW  = 3'd4;
  localparam logic [MEM_CTRL_WIDTH-1:0] MEM_RWU = 3'd5;

  // Works on a 64-bit container so one implementation serves both widths.
  // RV32 callers zero-extend rdata and truncate the result; because the
  // upper container bits are zero, a misaligned RV32 access that runs off
  // the word still yields defined (zero-filled) bits rather than X.
  function automatic logic [63:0] wb_load_format(
    input logic [63:0]               rdata,
    input logic [2:0]                offset,
    input logic [MEM_CTRL_WIDTH-1:0] mem_ctrl,
    input int unsigned               width
  );
    logic [63:0] shifted;
    logic [63:0] res;
    shifted = rdata >> {offset, 3'b000};
    case (mem_ctrl)
      MEM_RB:  res = {{56{shifted[7]}}, shifted[7:0]};
      MEM_RBU: res = {56'd0, shifted[7:0]};
      MEM_RH:  res = {{48{shifted[15]}}, shifted[15:0]};
      MEM_RHU: res = {48'd0, shifted[15:0]};
      // Word loads only narrow on RV64; on RV32 the word is the full datum.
      MEM_RW:  res = (width == 64) ? {{32{shifted[31]}}, shifted[31:0]} : rdata;
      MEM_RWU: res = (width == 64) ? {32'd0, shifted[31:0]} : rdata;
      default: res = rdata;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/wb_rsp_fifo.sv
// -----------------------------------------------------------------------------
// wb_rsp_fifo
// Small synchronous FIFO buffering OBI read responses ({err, rdata}).
//   clk_i, rst_i  : clock, synchronous active-high reset (empties the FIFO)
//   push_i        : write wdata_i (dropped if full and not popping)
//   pop_i         : retire the oldest entry (ignored when empty)
//   wdata_i       : entry to write
//   rdata_o       : oldest entry (valid when empty_o is low)
//   empty_o       : no entries held
//   overflow_o    : sticky, set when a push is dropped; cleared by reset
// -----------------------------------------------------------------------------
module wb_rsp_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             overflow_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             overflow_q;
  logic             full;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign do_push = push_i && (!full || do_pop);

  // NOTE: storage carries no reset; the count and pointers alone decide
  // which entries are meaningful, and skipping the reset keeps it a plain RAM.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow is the wrap.
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
      if (push_i && !do_push) overflow_q <= 1'b1;
    end
  end

  assign rdata_o    = mem_q[rd_ptr_q];
  assign overflow_o = overflow_q;

endmodule

// File: rtl/writeback_stage.sv
// -----------------------------------------------------------------------------
// writeback_stage
// Registered write-back stage (RV32/RV64). Accepts one instruction per cycle
// from MEM, matches loads with OBI read responses (buffered in wb_rsp_fifo so
// a response may precede its load), and drives one-cycle GPR/CSR write
// strobes plus a retire strobe.
//   clk_i, rst_i            : clock, synchronous active-high reset
//   valid_i / ready_o       : instruction handshake from MEM
//   exe_out_i, op3_i        : EXE result (also load address), aux operand
//   rd_i, csr_waddr_i       : destination GPR index, CSR address
//   gpr_ctrl_i, csr_ctrl_i  : write-back source, CSR operation
//   mem_ctrl_i              : load width/sign
//   rvalid_i, rdata_i, err_i: OBI response channel
//   rd_o, gpr_wdata_o, gpr_wdata_valid_o : GPR write port
//   csr_waddr_o, csr_wdata_o, csr_wdata_valid_o : CSR write port
//   retire_o, load_err_o    : commit and load-error strobes
//   rsp_overflow_o          : sticky response-FIFO overflow
// -----------------------------------------------------------------------------
module writeback_stage
  import core_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int RF_ADDR_WIDTH  = 5,
  parameter int CSR_ADDR_WIDTH = 12,
  parameter int RSP_DEPTH      = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic [DATA_WIDTH-1:0]     exe_out_i,
  input  logic [DATA_WIDTH-1:0]     op3_i,
  input  logic [RF_ADDR_WIDTH-1:0]  rd_i,
  input  logic [CSR_ADDR_WIDTH-1:0] csr_waddr_i,
  input  logic [GPR_CTRL_WIDTH-1:0] gpr_ctrl_i,
  input  logic [CSR_CTRL_WIDTH-1:0] csr_ctrl_i,
  input  logic [MEM_CTRL_WIDTH-1:0] mem_ctrl_i,
  input  logic                      rvalid_i,
  input  logic [DATA_WIDTH-1:0]     rdata_i,
  input  logic                      err_i,
  output logic [RF_ADDR_WIDTH-1:0]  rd_o,
  output logic [DATA_WIDTH-1:0]     gpr_wdata_o,
  output logic                      gpr_wdata_valid_o,
  output logic [CSR_ADDR_WIDTH-1:0] csr_waddr_o,
  output logic [DATA_WIDTH-1:0]     csr_wdata_o,
  output logic                      csr_wdata_valid_o,
  output logic                      retire_o,
  output logic                      load_err_o,
  output logic                      rsp_overflow_o
);

  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
    $error("writeback_stage: DATA_WIDTH must be 32 or 64");
  end
  if (RSP_DEPTH < 2 || (RSP_DEPTH & (RSP_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("writeback_stage: RSP_DEPTH must be a power of two >= 2");
  end

  localparam int OFF_W = (DATA_WIDTH == 64) ? 3 : 2;

  typedef enum logic {RUN, WAIT_RSP} state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]     exe_out;
    logic [DATA_WIDTH-1:0]     op3;
    logic [RF_ADDR_WIDTH-1:0]  rd;
    logic [CSR_ADDR_WIDTH-1:0] csr_waddr;
    logic [GPR_CTRL_WIDTH-1:0] gpr_ctrl;
    logic [CSR_CTRL_WIDTH-1:0] csr_ctrl;
    logic [MEM_CTRL_WIDTH-1:0] mem_ctrl;
  } instr_t;

  state_e state_q, state_d;
  instr_t instr_q, instr_d;
  instr_t in_instr, cur;

  logic                  fifo_pop, fifo_push, fifo_empty, fifo_overflow;
  logic [DATA_WIDTH:0]   fifo_rdata;
  logic                  rvalid_used;
  logic                  commit;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_err;
  logic                  is_load;
  logic [DATA_WIDTH-1:0] gpr_data;

  assign in_instr = '{exe_out:   exe_out_i,
                      op3:       op3_i,
                      rd:        rd_i,
                      csr_waddr: csr_waddr_i,
                      gpr_ctrl:  gpr_ctrl_i,
                      csr_ctrl:  csr_ctrl_i,
                      mem_ctrl:  mem_ctrl_i};

  assign ready_o = (state_q == RUN);

  // NOTE: every always_comb output gets a default first, so no path through
  // the case statements can leave a value unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    cur         = in_instr;
    fifo_pop    = 1'b0;
    rvalid_used = 1'b0;
    commit      = 1'b0;
    rsp_data    = rdata_i;
    rsp_err     = err_i;
    case (state_q)
      RUN: begin
        if (valid_i) begin
          if (in_instr.gpr_ctrl != GPR_MEM) begin
            commit = 1'b1;
          end else if (!fifo_empty) begin
            // Buffered responses are older than anything on the bus now.
            fifo_pop = 1'b1;
            commit   = 1'b1;
            rsp_data = fifo_rdata[DATA_WIDTH-1:0];
            rsp_err  = fifo_rdata[DATA_WIDTH];
          end else if (rvalid_i) begin
            rvalid_used = 1'b1;
            commit      = 1'b1;
          end else begin
            instr_d = in_instr;
            state_d = WAIT_RSP;
          end
        end
      end
      WAIT_RSP: begin
        // The FIFO is always empty here: we only enter with it empty and
        // every response seen while waiting is consumed directly.
        cur = instr_q;
        if (rvalid_i) begin
          rvalid_used = 1'b1;
          commit      = 1'b1;
          state_d     = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign fifo_push = rvalid_i && !rvalid_used;
  assign is_load   = (cur.gpr_ctrl == GPR_MEM);

  always_comb begin
    gpr_data = cur.exe_out;
    case (cur.gpr_ctrl)
      GPR_ALU:   gpr_data = cur.exe_out;
      GPR_PRGMC: gpr_data = cur.op3 + DATA_WIDTH'(4);
      GPR_OP3:   gpr_data = cur.op3;
      GPR_MEM:   gpr_data = DATA_WIDTH'(wb_load_format(64'(rsp_data),
                                                       3'(cur.exe_out[OFF_W-1:0]),
                                                       cur.mem_ctrl,
                                                       DATA_WIDTH));
      default:   gpr_data = cur.exe_out;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q           <= RUN;
      instr_q           <= '0;
      rd_o              <= '0;
      gpr_wdata_o       <= '0;
      gpr_wdata_valid_o <= 1'b0;
      csr_waddr_o       <= '0;
      csr_wdata_o       <= '0;
      csr_wdata_valid_o <= 1'b0;
      retire_o          <= 1'b0;
      load_err_o        <= 1'b0;
    end else begin
      state_q           <= state_d;
      instr_q           <= instr_d;
      gpr_wdata_valid_o <= commit && (cur.gpr_ctrl != GPR_IDLE) && !(is_load && rsp_err);
      csr_wdata_valid_o <= commit && (cur.csr_ctrl != CSR_IDLE);
      retire_o          <= commit;
      load_err_o        <= commit && is_load && rsp_err;
      // Address/data hold their last committed values between commits.
      if (commit) begin
        rd_o        <= cur.rd;
        gpr_wdata_o <= gpr_data;
        csr_waddr_o <= cur.csr_waddr;
        csr_wdata_o <= cur.exe_out;
      end
    end
  end

  wb_rsp_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (fifo_push),
    .pop_i      (fifo_pop),
    .wdata_i    ({err_i, rdata_i}),
    .rdata_o    (fifo_rdata),
    .empty_o    (fifo_empty),
    .overflow_o (fifo_overflow)
  );

  assign rsp_overflow_o = fifo_overflow;

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;
  import core_pkg::*;

  int errors = 0;
  int checks = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Shared control inputs
  logic [4:0]                rd = '0;
  logic [11:0]               csr_waddr = '0;
  logic [GPR_CTRL_WIDTH-1:0] gpr_ctrl = GPR_IDLE;
  logic [CSR_CTRL_WIDTH-1:0] csr_ctrl = CSR_IDLE;
  logic [MEM_CTRL_WIDTH-1:0] mem_ctrl = MEM_RB;
  logic                      err = 1'b0;

  // RV32 instance
  logic        valid = 1'b0, rvalid = 1'b0;
  logic [31:0] exe_out = '0, op3 = '0, rdata = '0;
  logic        ready;
  logic [4:0]  rd_o;
  logic [31:0] gpr_wdata, csr_wdata;
  logic [11:0] csr_waddr_o;
  logic        gpr_v, csr_v, retire, load_err, ovf;

  // RV64 instance
  logic        valid64 = 1'b0, rvalid64 = 1'b0;
  logic [63:0] exe64 = '0, op364 = '0, rdata64 = '0;
  logic        ready64;
  logic [4:0]  rd_o64;
  logic [63:0] gpr_wdata64, csr_wdata64;
  logic [11:0] csr_waddr_o64;
  logic        gpr_v64, csr_v64, retire64, load_err64, ovf64;

  writeback_stage #(.DATA_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .ready_o(ready),
    .exe_out_i(exe_out), .op3_i(op3), .rd_i(rd), .csr_waddr_i(csr_waddr),
    .gpr_ctrl_i(gpr_ctrl), .csr_ctrl_i(csr_ctrl), .mem_ctrl_i(mem_ctrl),
    .rvalid_i(rvalid), .rdata_i(rdata), .err_i(err),
    .rd_o(rd_o), .gpr_wdata_o(gpr_wdata), .gpr_wdata_valid_o(gpr_v),
    .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata), .csr_wdata_valid_o(csr_v),
    .retire_o(retire), .load_err_o(load_err), .rsp_overflow_o(ovf)
  );

  writeback_stage #(.DATA_WIDTH(64)) dut64 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid64), .ready_o(ready64),
    .exe_out_i(exe64), .op3_i(op364), .rd_i(rd), .csr_waddr_i(csr_waddr),
    .gpr_ctrl_i(gpr_ctrl), .csr_ctrl_i(csr_ctrl), .mem_ctrl_i(mem_ctrl),
    .rvalid_i(rvalid64), .rdata_i(rdata64), .err_i(err),
    .rd_o(rd_o64), .gpr_wdata_o(gpr_wdata64), .gpr_wdata_valid_o(gpr_v64),
    .csr_waddr_o(csr_waddr_o64), .csr_wdata_o(csr_wdata64), .csr_wdata_valid_o(csr_v64),
    .retire_o(retire64), .load_err_o(load_err64), .rsp_overflow_o(ovf64)
  );

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({rd_o, gpr_wdata, gpr_v, csr_waddr_o, csr_wdata, csr_v, retire, load_err, ovf} !== '0) begin
      errors++;
      $display("FAIL reset_outputs32: got rd=%h gd=%h gv=%b ca=%h cd=%h cv=%b ret=%b le=%b ovf=%b, want all 0",
               rd_o, gpr_wdata, gpr_v, csr_waddr_o, csr_wdata, csr_v, retire, load_err, ovf);
    end
    checks++;
    if ({rd_o64, gpr_wdata64, gpr_v64, csr_waddr_o64, csr_wdata64, csr_v64, retire64, load_err64, ovf64} !== '0) begin
      errors++;
      $display("FAIL reset_outputs64: outputs not all zero");
    end
    checks++;
    if ({ready, ready64} !== 2'b11) begin
      errors++;
      $display("FAIL reset_ready: got %b%b want 11", ready, ready64);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({retire, retire64} !== 2'b00) begin
      errors++;
      $display("FAIL reset_no_retire: got %b%b want 00", retire, retire64);
    end
  endtask

  task automatic test_alu();
    valid = 1'b1; gpr_ctrl = GPR_ALU; rd = 5'd5; exe_out = 32'h1234; csr_ctrl = CSR_IDLE;
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL alu_ready_before: got %b want 1", ready); end
    tick();
    checks++;
    if ({gpr_v, csr_v, retire, load_err} !== 4'b1010) begin
      errors++; $display("FAIL alu_strobes: got gv/cv/ret/le=%b want 1010", {gpr_v, csr_v, retire, load_err});
    end
    checks++;
    if (rd_o !== 5'd5 || gpr_wdata !== 32'h1234) begin
      errors++; $display("FAIL alu_data: got rd=%0d data=%h want rd=5 data=00001234", rd_o, gpr_wdata);
    end
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL alu_ready_after: got %b want 1", ready); end
    valid = 1'b0;
    tick();
    checks++;
    if ({gpr_v, retire} !== 2'b00 || rd_o !== 5'd5) begin
      errors++; $display("FAIL alu_idle_hold: got gv=%b ret=%b rd=%0d want 0 0 5", gpr_v, retire, rd_o);
    end
  endtask

  task automatic test_back_to_back();
    valid = 1'b1; gpr_ctrl = GPR_ALU; rd = 5'd1; exe_out = 32'hAAAA_5555;
    tick();
    checks++;
    if (gpr_wdata !== 32'hAAAA_5555 || rd_o !== 5'd1 || gpr_v !== 1'b1) begin
      errors++; $display("FAIL b2b_alu: got %h rd=%0d gv=%b want aaaa5555 rd=1 gv=1", gpr_wdata, rd_o, gpr_v);
    end
    gpr_ctrl = GPR_PRGMC; rd = 5'd2; op3 = 32'h100;
    tick();
    checks++;
    if (gpr_wdata !== 32'h104 || rd_o !== 5'd2 || retire !== 1'b1) begin
      errors++; $display("FAIL b2b_prgmc: got %h rd=%0d ret=%b want 00000104 rd=2 ret=1", gpr_wdata, rd_o, retire);
    end
    gpr_ctrl = GPR_OP3; rd = 5'd3; op3 = 32'hDEAD_BEEF;
    tick();
    checks++;
    if (gpr_wdata !== 32'hDEAD_BEEF || rd_o !== 5'd3) begin
      errors++; $display("FAIL b2b_op3: got %h rd=%0d want deadbeef rd=3", gpr_wdata, rd_o);
    end
    gpr_ctrl = GPR_PRGMC; rd = 5'd4; op3 = 32'hFFFF_FFFC;
    tick();
    checks++;
    if (gpr_wdata !== 32'h0 || gpr_v !== 1'b1) begin
      errors++; $display("FAIL prgmc_wrap32: got %h gv=%b want 00000000 gv=1", gpr_wdata, gpr_v);
    end
    gpr_ctrl = GPR_IDLE; csr_ctrl = CSR_WRITE; csr_waddr = 12'h300; exe_out = 32'hABCD;
    tick();
    checks++;
    if ({gpr_v, csr_v, retire} !== 3'b011 || csr_waddr_o !== 12'h300 || csr_wdata !== 32'hABCD) begin
      errors++; $display("FAIL csr_write: got gv/cv/ret=%b addr=%h data=%h want 011 300 0000abcd",
                         {gpr_v, csr_v, retire}, csr_waddr_o, csr_wdata);
    end
    valid = 1'b0; csr_ctrl = CSR_IDLE;
    tick();
    checks++;
    if ({gpr_v, csr_v, retire} !== 3'b000 || csr_waddr_o !== 12'h300) begin
      errors++; $display("FAIL strobes_drop: got %b addr=%h want 000 300", {gpr_v, csr_v, retire}, csr_waddr_o);
    end
  endtask

  task automatic test_load_wait();
    valid = 1'b1; gpr_ctrl = GPR_MEM; mem_ctrl = MEM_RB; exe_out = 32'h1003; rd = 5'd7;
    tick();
    checks++;
    if (ready !== 1'b0 || retire !== 1'b0) begin
      errors++; $display("FAIL lb_wait_enter: got ready=%b ret=%b want 0 0", ready, retire);
    end
    valid = 1'b0; exe_out = 32'h0;
    tick();
    tick();
    checks++;
    if (ready !== 1'b0 || retire !== 1'b0) begin
      errors++; $display("FAIL lb_wait_hold: got ready=%b ret=%b want 0 0", ready, retire);
    end
    rvalid = 1'b1; rdata = 32'h80FF_FFFF;
    tick();
    rvalid = 1'b0;
    checks++;
    if (gpr_wdata !== 32'hFFFF_FF80 || gpr_v !== 1'b1 || retire !== 1'b1 || rd_o !== 5'd7) begin
      errors++; $display("FAIL lb_wait_commit: got %h gv=%b ret=%b rd=%0d want ffffff80 1 1 7",
                         gpr_wdata, gpr_v, retire, rd_o);
    end
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL lb_wait_ready: got %b want 1", ready); end
    // Bypass loads: response arrives in the transfer cycle.
    valid = 1'b1; rvalid = 1'b1; mem_ctrl = MEM_RH; exe_out = 32'h2; rdata = 32'h8001_0000;
    tick();
    checks++;
    if (gpr_wdata !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_off2: got %h want ffff8001", gpr_wdata); end
    mem_ctrl = MEM_RBU; exe_out = 32'h1; rdata = 32'h0000_F000;
    tick();
    checks++;
    if (gpr_wdata !== 32'h0000_00F0) begin errors++; $display("FAIL lbu_off1: got %h want 000000f0", gpr_wdata); end
    valid = 1'b0; rvalid = 1'b0;
    tick();
  endtask

  task automatic test_early_rsp();
    rvalid = 1'b1; rdata = 32'h0000_BEEF;
    tick();
    rvalid = 1'b0; rdata = 32'h0;
    tick();
    valid = 1'b1; gpr_ctrl = GPR_MEM; mem_ctrl = MEM_RHU; exe_out = 32'h2000; rd = 5'd9;
    tick();
    checks++;
    if (gpr_wdata !== 32'h0000_BEEF || gpr_v !== 1'b1 || rd_o !== 5'd9) begin
      errors++; $display("FAIL early_rsp: got %h gv=%b rd=%0d want 0000beef 1 9", gpr_wdata, gpr_v, rd_o);
    end
    // FIFO must now be empty: the next load has to wait.
    mem_ctrl = MEM_RW; exe_out = 32'h0;
    tick();
    valid = 1'b0;
    checks++;
    if (ready !== 1'b0 || retire !== 1'b0) begin
      errors++; $display("FAIL early_fifo_empty: got ready=%b ret=%b want 0 0", ready, retire);
    end
    rvalid = 1'b1; rdata = 32'h1234_5678;
    tick();
    rvalid = 1'b0;
    checks++;
    if (gpr_wdata !== 32'h1234_5678 || retire !== 1'b1) begin
      errors++; $display("FAIL lw_rv32_full: got %h ret=%b want 12345678 1", gpr_wdata, retire);
    end
  endtask

  task automatic test_error();
    valid = 1'b1; gpr_ctrl = GPR_MEM; mem_ctrl = MEM_RW; exe_out = 32'h0; rd = 5'd4;
    rvalid = 1'b1; err = 1'b1; rdata = 32'hFFFF;
    tick();
    valid = 1'b0; rvalid = 1'b0; err = 1'b0;
    checks++;
    if ({load_err, gpr_v, retire} !== 3'b101) begin
      errors++; $display("FAIL load_err: got le/gv/ret=%b want 101", {load_err, gpr_v, retire});
    end
    tick();
    checks++;
    if (load_err !== 1'b0) begin errors++; $display("FAIL load_err_pulse: got %b want 0", load_err); end
  endtask

  task automatic test_overflow();
    rvalid = 1'b1; rdata = 32'h11;
    tick();
    rdata = 32'h22;
    tick();
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_not_yet: got %b want 0", ovf); end
    rdata = 32'h33;
    tick();
    rvalid = 1'b0;
    checks++;
    if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", ovf); end
    tick();
    tick();
    checks++;
    if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
    // Pop oldest while a new response is pushed into the full FIFO.
    valid = 1'b1; gpr_ctrl = GPR_MEM; mem_ctrl = MEM_RBU; exe_out = 32'h0;
    rvalid = 1'b1; rdata = 32'h44;
    tick();
    rvalid = 1'b0;
    checks++;
    if (gpr_wdata !== 32'h11 || retire !== 1'b1) begin
      errors++; $display("FAIL fifo_oldest: got %h ret=%b want 00000011 1", gpr_wdata, retire);
    end
    tick();
    valid = 1'b0;
    checks++;
    if (gpr_wdata !== 32'h22 || retire !== 1'b1) begin
      errors++; $display("FAIL fifo_second: got %h ret=%b want 00000022 1", gpr_wdata, retire);
    end
  endtask

  task automatic test_reset_mid();
    // One response (0x44) is still buffered here.
    rst = 1'b1;
    tick();
    checks++;
    if ({rd_o, gpr_wdata, gpr_v, csr_waddr_o, csr_wdata, csr_v, retire, load_err, ovf} !== '0) begin
      errors++; $display("FAIL reset_mid_outputs: got gd=%h ovf=%b ret=%b want all 0", gpr_wdata, ovf, retire);
    end
    rst = 1'b0;
    valid = 1'b1; gpr_ctrl = GPR_MEM; mem_ctrl = MEM_RW; exe_out = 32'h0; rd = 5'd6;
    tick();
    valid = 1'b0;
    checks++;
    if (ready !== 1'b0 || retire !== 1'b0) begin
      errors++; $display("FAIL reset_dropped_fifo: got ready=%b ret=%b want 0 0", ready, retire);
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (ready !== 1'b1 || retire !== 1'b0 || gpr_v !== 1'b0) begin
      errors++; $display("FAIL reset_in_wait: got ready=%b ret=%b gv=%b want 1 0 0", ready, retire, gpr_v);
    end
    tick();
    valid = 1'b1;
    tick();
    valid = 1'b0;
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL reset_fresh_wait: got ready=%b want 0", ready); end
    rvalid = 1'b1; rdata = 32'h66;
    tick();
    rvalid = 1'b0;
    checks++;
    if (gpr_wdata !== 32'h66 || retire !== 1'b1 || rd_o !== 5'd6) begin
      errors++; $display("FAIL reset_fresh_commit: got %h ret=%b rd=%0d want 00000066 1 6", gpr_wdata, retire, rd_o);
    end
  endtask

  task automatic test_rv64();
    valid64 = 1'b1; rvalid64 = 1'b1; gpr_ctrl = GPR_MEM; mem_ctrl = MEM_RW; rd = 5'd10;
    exe64 = 64'h4; rdata64 = 64'h8000_0001_0000_0000;
    tick();
    checks++;
    if (gpr_wdata64 !== 64'hFFFF_FFFF_8000_0001 || gpr_v64 !== 1'b1) begin
      errors++; $display("FAIL rv64_lw_off4: got %h gv=%b want ffffffff80000001 1", gpr_wdata64, gpr_v64);
    end
    mem_ctrl = MEM_RWU; exe64 = 64'h0; rdata64 = 64'h1234_5678_9ABC_DEF0;
    tick();
    checks++;
    if (gpr_wdata64 !== 64'h0000_0000_9ABC_DEF0) begin
      errors++; $display("FAIL rv64_lwu: got %h want 000000009abcdef0", gpr_wdata64);
    end
    mem_ctrl = MEM_RB; exe64 = 64'h7; rdata64 = 64'h7F00_0000_0000_0000;
    tick();
    checks++;
    if (gpr_wdata64 !== 64'h7F) begin
      errors++; $display("FAIL rv64_lb_off7: got %h want 000000000000007f", gpr_wdata64);
    end
    rvalid64 = 1'b0; gpr_ctrl = GPR_PRGMC; op364 = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    valid64 = 1'b0;
    checks++;
    if (gpr_wdata64 !== 64'h0 || gpr_v64 !== 1'b1 || retire64 !== 1'b1) begin
      errors++; $display("FAIL rv64_prgmc_wrap: got %h gv=%b ret=%b want 0 1 1", gpr_wdata64, gpr_v64, retire64);
    end
    tick();
    checks++;
    if (retire64 !== 1'b0) begin errors++; $display("FAIL rv64_idle: got ret=%b want 0", retire64); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_back_to_back();
    test_load_wait();
    test_early_rsp();
    test_error();
    test_overflow();
    test_reset_mid();
    test_rv64();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
Registered write-back stage of the SCHOLAR RISC-V pipeline, parametrised for RV32/RV64 (DATA_WIDTH 32/64). It takes one instruction per cycle from the MEM stage through a valid/ready handshake and captures OBI read responses (rvalid/rdata/err) in a small response FIFO, so a response may arrive before, with, or after its load. It formats load data (byte/half/word, signed/unsigned, offset-aligned) and drives registered, one-cycle-pulsed GPR and CSR write ports plus a retire strobe.

Parameters:
DATA_WIDTH, 32, datapath width; legal values are 32 and 64 only. Elaboration error otherwise.
RF_ADDR_WIDTH, 5, GPR index width.
CSR_ADDR_WIDTH, 12, CSR address width.
RSP_DEPTH, 2, OBI response FIFO entries; power of two, at least 2.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
valid_i  in  1  MEM stage presents an instruction
ready_o  out  1  stage can accept an instruction this cycle
exe_out_i  in  DATA_WIDTH  EXE result; low offset bits give the load byte offset
op3_i  in  DATA_WIDTH  auxiliary operand (PC for PRGMC, CSR read value for OP3)
rd_i  in  RF_ADDR_WIDTH  destination GPR
csr_waddr_i  in  CSR_ADDR_WIDTH  CSR write address
gpr_ctrl_i  in  GPR_CTRL_WIDTH  GPR_IDLE/ALU/PRGMC/OP3/MEM
csr_ctrl_i  in  CSR_CTRL_WIDTH  CSR_IDLE means no CSR write
mem_ctrl_i  in  MEM_CTRL_WIDTH  load width and sign (MEM_RB..MEM_RWU)
rvalid_i  in  1  OBI response valid
rdata_i  in  DATA_WIDTH  OBI response data
err_i  in  1  OBI response error
rd_o  out  RF_ADDR_WIDTH  GPR write index
gpr_wdata_o  out  DATA_WIDTH  GPR write data
gpr_wdata_valid_o  out  1  GPR write strobe, one cycle
csr_waddr_o  out  CSR_ADDR_WIDTH  CSR write address
csr_wdata_o  out  DATA_WIDTH  CSR write data (exe_out)
csr_wdata_valid_o  out  1  CSR write strobe, one cycle
retire_o  out  1  instruction committed this cycle
load_err_o  out  1  committed load had an OBI error, one cycle
rsp_overflow_o  out  1  sticky: response arrived while FIFO full

Behaviour:
- Reset (rst_i=1 at an edge): all outputs 0, FIFO empty, FSM in RUN, instruction register invalid. Reset mid-load drops the pending load and all buffered responses. Nothing retires.
- ready_o = (state==RUN). Transfer occurs when valid_i and ready_o are both high.
- FSM states:
  - RUN: on a transfer of a non-load (gpr_ctrl_i != GPR_MEM), commit at the next edge. Latency 1; throughput 1 per cycle.
  - On a load transfer: if the FIFO is non-empty, or rvalid_i is high this cycle (bypass), pop/consume it and commit at the next edge. Otherwise latch the instruction fields and go to WAIT_RSP.
  - WAIT_RSP: ready_o=0. On rvalid_i, commit at the next edge and return to RUN. The response bypasses the FIFO.
- FIFO: push on rvalid_i unless consumed the same cycle. Simultaneous push and pop on a non-empty FIFO is allowed; the pop returns the oldest entry. Push when full: data dropped and rsp_overflow_o set, cleared only by reset. Pointers wrap modulo RSP_DEPTH.
- Commit cycle (registered outputs; all strobes low otherwise):
  - gpr_wdata_valid_o = (gpr_ctrl != GPR_IDLE) and not load error.
  - csr_wdata_valid_o = (csr_ctrl != CSR_IDLE).
  - retire_o = 1.
  - load_err_o = load and err.
- GPR data by gpr_ctrl:
  - ALU: exe_out.
  - PRGMC: op3+4, wraps modulo 2^DATA_WIDTH.
  - OP3: op3.
  - MEM: byte offset = exe_out[log2(DATA_WIDTH/8)-1:0]. Select 8/16/32 bits at offset*8, then sign- or zero-extend per mem_ctrl.
  - MEM_RW/RWU are honoured only when DATA_WIDTH=64; on RV32 they and any other code take full rdata.
  - Misaligned accesses crossing the word boundary are not supported; result is undefined but must not produce X.
- rd_o and csr_waddr_o hold the last committed values between commits.

Decomposition:
- core_pkg: GPR_*, CSR_*, MEM_* encodings, *_CTRL_WIDTH, and a function wb_load_format(rdata, offset, mem_ctrl, width) shared by RV32/RV64.
- Local typedefs: FSM state enum {RUN, WAIT_RSP}, and a packed instruction struct {exe_out, op3, rd, csr_waddr, ctrls}.
- One sub-module: wb_rsp_fifo (synchronous FIFO, DATA_WIDTH+1 bits wide, parametrised depth, full/empty/overflow).

Test Plan:
- ALU: valid_i, gpr_ctrl=ALU, rd=5, exe_out=0x1234 -> next cycle gpr_wdata_valid_o=1, rd_o=5, gpr_wdata_o=0x1234, retire_o=1, ready_o stays 1.
- Load LB waiting: exe_out=0x1003, no response -> ready_o=0; rvalid_i 3 cycles later with rdata=0x80FF_FFFF -> next cycle gpr_wdata_o=0xFFFF_FF80, ready_o=1.
- Early response: rvalid_i rdata=0x0000_BEEF two cycles before an LHU at offset 0 -> commits 1 cycle after transfer with 0x0000_BEEF, FIFO empty.
- Error and overflow: load response with err_i=1 -> load_err_o=1, gpr_wdata_valid_o=0. Three unconsumed rvalid with RSP_DEPTH=2 -> rsp_overflow_o=1, held until reset.
- RV64 (DATA_WIDTH=64): LW at offset 4 with rdata=0x8000_0001_0000_0000 -> 0xFFFF_FFFF_8000_0001. PRGMC with op3=0xFFFF_FFFF_FFFF_FFFC -> 0.
- Reset during WAIT_RSP with one buffered response -> all outputs 0, ready_o=1 after release, later load waits for a fresh response.
